// File: rtl/irq_ctrl.sv
// irq_ctrl: multi-channel interrupt controller with a fixed-priority arbiter,
// a trap req/ack handshake to the pipeline, mret return handling and a
// non-maskable watchdog path that pulses a pipeline reset.
//
// Ports:
//   clk, rst (sync, active-low)
//   irq_in       raw interrupt lines (edge/level per EDGE_MASK)
//   wdt_timeout  non-maskable watchdog timeout
//   mask_wr/mask_wdata, gie_wr/gie_wdata   CSR writes
//   stall        pipeline stall, blocks trap acceptance and mret
//   trap_pc      PC in EXE, saved as return PC on acceptance
//   trap_ack     pipeline accepts the trap
//   mret         mret executing in EXE
//   trap_req/trap_vector/trap_id   trap request, ISR target, winning channel
//   ret_valid/ret_pc               one-cycle return redirect and saved epc
//   sys_reset    one-cycle reset pulse to the pipeline registers
//   gie, pending CSR readback
module irq_ctrl #(
  parameter int unsigned        N_IRQ      = 4,
  parameter logic [N_IRQ-1:0]   EDGE_MASK  = N_IRQ'(1),
  parameter logic [31:0]        VEC_BASE   = 32'h0001_0000,
  parameter logic [31:0]        VEC_STRIDE = 32'h0000_0010,
  localparam int unsigned       ID_W       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             wdt_timeout,
  input  logic             mask_wr,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             gie_wr,
  input  logic             gie_wdata,
  input  logic             stall,
  input  logic [31:0]      trap_pc,
  input  logic             trap_ack,
  input  logic             mret,
  output logic             trap_req,
  output logic [31:0]      trap_vector,
  output logic [ID_W-1:0]  trap_id,
  output logic             ret_valid,
  output logic [31:0]      ret_pc,
  output logic             sys_reset,
  output logic             gie,
  output logic [N_IRQ-1:0] pending
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ISR  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               gie_q, gie_d;
  logic               mpie_q, mpie_d;
  logic [N_IRQ-1:0]   mask_q, mask_d;
  logic [N_IRQ-1:0]   pending_q, pending_d;
  logic [N_IRQ-1:0]   prev_irq_q;
  logic [31:0]        epc_q, epc_d;
  logic [ID_W-1:0]    trap_id_q, trap_id_d;
  logic               ret_valid_q, ret_valid_d;
  logic               sys_reset_q, sys_reset_d;
  logic               wdt_prev_q;

  logic [N_IRQ-1:0]   elig;
  logic [ID_W-1:0]    winner;
  logic               accept;
  logic               ret_now;
  logic               withdraw;

  // Lowest eligible index wins; scanning downward leaves the lowest one last.
  always_comb begin
    elig   = pending_q & mask_q;
    winner = '0;
    for (int unsigned i = N_IRQ; i > 0; i--) begin
      if (elig[i-1]) winner = ID_W'(i - 1);
    end
  end

  always_comb begin
    accept   = (state_q == S_REQ) && trap_ack && !stall;
    ret_now  = (state_q == S_ISR) && mret && !stall;
    // Software withdrawing the request only matters if the pipeline did not
    // take the trap in the same cycle; acceptance wins the conflict.
    withdraw = (state_q == S_REQ) && !accept &&
               ((gie_wr && !gie_wdata) || (mask_wr && !mask_wdata[trap_id_q]));
  end

  always_comb begin
    state_d     = state_q;
    gie_d       = gie_q;
    mpie_d      = mpie_q;
    mask_d      = mask_q;
    epc_d       = epc_q;
    trap_id_d   = trap_id_q;
    ret_valid_d = 1'b0;
    sys_reset_d = 1'b0;
    pending_d   = pending_q;

    if (wdt_timeout) begin
      // Watchdog overrides everything; mask and epc survive it.
      sys_reset_d = !wdt_prev_q;
      state_d     = S_IDLE;
      gie_d       = 1'b0;
      mpie_d      = 1'b0;
      pending_d   = '0;
    end else begin
      for (int unsigned i = 0; i < N_IRQ; i++) begin
        if (EDGE_MASK[i]) begin
          // A new rising edge in the acceptance cycle must not be lost.
          pending_d[i] = (irq_in[i] && !prev_irq_q[i]) ||
                         (pending_q[i] && !(accept && (trap_id_q == ID_W'(i))));
        end else begin
          pending_d[i] = irq_in[i];
        end
      end

      if (mask_wr) mask_d = mask_wdata;

      unique case (state_q)
        S_IDLE: begin
          if (gie_q && (elig != '0)) begin
            state_d   = S_REQ;
            trap_id_d = winner;
          end
          if (gie_wr) gie_d = gie_wdata;
        end
        S_REQ: begin
          if (accept) begin
            state_d = S_ISR;
            epc_d   = trap_pc;
            mpie_d  = gie_q;
            gie_d   = 1'b0;
          end else begin
            if (withdraw) state_d = S_IDLE;
            if (gie_wr) gie_d = gie_wdata;
          end
        end
        S_ISR: begin
          if (ret_now) begin
            state_d     = S_IDLE;
            gie_d       = mpie_q;
            ret_valid_d = 1'b1;
          end else if (gie_wr) begin
            gie_d = gie_wdata;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      gie_q       <= 1'b0;
      mpie_q      <= 1'b0;
      mask_q      <= '0;
      pending_q   <= '0;
      prev_irq_q  <= '0;
      epc_q       <= '0;
      trap_id_q   <= '0;
      ret_valid_q <= 1'b0;
      sys_reset_q <= 1'b0;
      wdt_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gie_q       <= gie_d;
      mpie_q      <= mpie_d;
      mask_q      <= mask_d;
      pending_q   <= pending_d;
      prev_irq_q  <= irq_in;
      epc_q       <= epc_d;
      trap_id_q   <= trap_id_d;
      ret_valid_q <= ret_valid_d;
      sys_reset_q <= sys_reset_d;
      wdt_prev_q  <= wdt_timeout;
    end
  end

  assign trap_req    = (state_q == S_REQ);
  assign trap_vector = VEC_BASE + (32'(trap_id_q) * VEC_STRIDE);
  assign trap_id     = trap_id_q;
  assign ret_valid   = ret_valid_q;
  assign ret_pc      = epc_q;
  assign sys_reset   = sys_reset_q;
  assign gie         = gie_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus a randomized run,
// all compared against a cycle-level behavioural model of the controller.
module tb_irq_ctrl;
  localparam int unsigned N  = 4;
  localparam logic [3:0]  EM = 4'b0001;
  localparam logic [31:0] VB = 32'h0001_0000;
  localparam logic [31:0] VS = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_in;
  logic        wdt_timeout, mask_wr, gie_wr, gie_wdata, stall, trap_ack, mret;
  logic [3:0]  mask_wdata;
  logic [31:0] trap_pc;
  logic        trap_req, ret_valid, sys_reset, gie;
  logic [31:0] trap_vector, ret_pc;
  logic [1:0]  trap_id;
  logic [3:0]  pending;

  always #5 clk = ~clk;

  irq_ctrl #(.N_IRQ(N), .EDGE_MASK(EM), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .wdt_timeout(wdt_timeout),
    .mask_wr(mask_wr), .mask_wdata(mask_wdata), .gie_wr(gie_wr),
    .gie_wdata(gie_wdata), .stall(stall), .trap_pc(trap_pc),
    .trap_ack(trap_ack), .mret(mret), .trap_req(trap_req),
    .trap_vector(trap_vector), .trap_id(trap_id), .ret_valid(ret_valid),
    .ret_pc(ret_pc), .sys_reset(sys_reset), .gie(gie), .pending(pending)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model: in_req / in_isr flags, not an encoded state.
  bit          m_req, m_isr, m_gie, m_mpie, m_ret, m_sys, m_wdtp;
  bit [3:0]    m_mask, m_pend, m_prev;
  int unsigned m_id;
  bit [31:0]   m_epc;

  task automatic model_step();
    int unsigned win;
    bit any, acc, rtn;
    if (!rst) begin
      m_req = 0; m_isr = 0; m_gie = 0; m_mpie = 0; m_ret = 0; m_sys = 0;
      m_wdtp = 0; m_mask = 0; m_pend = 0; m_prev = 0; m_id = 0; m_epc = 0;
      return;
    end
    if (wdt_timeout) begin
      m_sys = !m_wdtp; m_wdtp = 1;
      m_req = 0; m_isr = 0; m_gie = 0; m_mpie = 0; m_pend = 0; m_ret = 0;
      m_prev = irq_in;
      return;
    end
    m_wdtp = 0; m_sys = 0;
    any = 0; win = 0;
    for (int i = N - 1; i >= 0; i--)
      if (m_pend[i] && m_mask[i]) begin any = 1; win = i; end
    acc = m_req && trap_ack && !stall;
    rtn = m_isr && mret && !stall;
    m_ret = rtn;
    for (int i = 0; i < N; i++) begin
      if (EM[i]) m_pend[i] = (irq_in[i] && !m_prev[i]) || (m_pend[i] && !(acc && m_id == i));
      else       m_pend[i] = irq_in[i];
    end
    m_prev = irq_in;
    if (acc) begin
      m_epc = trap_pc; m_mpie = m_gie; m_gie = 0; m_req = 0; m_isr = 1;
    end else if (rtn) begin
      m_gie = m_mpie; m_isr = 0;
    end else begin
      if (m_req && ((gie_wr && !gie_wdata) || (mask_wr && !mask_wdata[m_id]))) m_req = 0;
      else if (!m_req && !m_isr && m_gie && any) begin m_req = 1; m_id = win; end
      if (gie_wr) m_gie = gie_wdata;
    end
    if (mask_wr) m_mask = mask_wdata;
  endtask

  function automatic logic [73:0] model_vec();
    logic [31:0] v;
    v = VB + m_id * VS;
    return {m_req, v, 2'(m_id), m_ret, m_epc, m_sys, m_gie, m_pend};
  endfunction

  function automatic logic [73:0] dut_vec();
    return {trap_req, trap_vector, trap_id, ret_valid, ret_pc, sys_reset, gie, pending};
  endfunction

  // Advance one clock with the current inputs; sample #1 after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    irq_in = 0; wdt_timeout = 0; mask_wr = 0; mask_wdata = 0; gie_wr = 0;
    gie_wdata = 0; stall = 0; trap_ack = 0; mret = 0; trap_pc = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    tick(); tick();
    tests++;
    if (dut_vec() !== model_vec()) begin
      fails++; $display("FAIL reset_model got=%h exp=%h", dut_vec(), model_vec());
    end
    tests++;
    if (trap_vector !== VB || {trap_req, trap_id, ret_valid, ret_pc, sys_reset, gie, pending} !== '0) begin
      fails++; $display("FAIL reset_values vec=%h req=%b pend=%b gie=%b", trap_vector, trap_req, pending, gie);
    end
    rst = 1;
    mask_wr = 1; mask_wdata = 4'hF; gie_wr = 1; gie_wdata = 1;
    tick();
    mask_wr = 0; gie_wr = 0;
  endtask

  task automatic test_basic();
    irq_in = 4'b0001; tick(); irq_in = 0;
    tests++;
    if (pending !== 4'b0001 || trap_req !== 1'b0) begin
      fails++; $display("FAIL basic_latency1 pend=%b req=%b exp pend=0001 req=0", pending, trap_req);
    end
    tick();
    tests++;
    if (trap_req !== 1'b1 || trap_vector !== 32'h0001_0000 || trap_id !== 2'd0) begin
      fails++; $display("FAIL basic_req req=%b vec=%h id=%0d exp 1/00010000/0", trap_req, trap_vector, trap_id);
    end
    trap_ack = 1; trap_pc = 32'h100; tick(); trap_ack = 0;
    tests++;
    if (gie !== 1'b0 || pending[0] !== 1'b0 || trap_req !== 1'b0) begin
      fails++; $display("FAIL basic_accept gie=%b pend=%b req=%b exp 0/xxx0/0", gie, pending, trap_req);
    end
    mret = 1; tick(); mret = 0;
    tests++;
    if (ret_valid !== 1'b1 || ret_pc !== 32'h100 || gie !== 1'b1) begin
      fails++; $display("FAIL basic_mret rv=%b pc=%h gie=%b exp 1/00000100/1", ret_valid, ret_pc, gie);
    end
    tick();
    tests++;
    if (ret_valid !== 1'b0 || dut_vec() !== model_vec()) begin
      fails++; $display("FAIL basic_after got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_level_priority();
    irq_in = 4'b0110; tick(); tick();
    tests++;
    if (trap_req !== 1'b1 || trap_id !== 2'd1 || trap_vector !== 32'h0001_0010) begin
      fails++; $display("FAIL level_prio req=%b id=%0d vec=%h exp 1/1/00010010", trap_req, trap_id, trap_vector);
    end
    trap_ack = 1; trap_pc = 32'h200; tick(); trap_ack = 0;
    irq_in = 4'b0100; mret = 1; tick(); mret = 0;
    tick();
    tests++;
    if (trap_req !== 1'b1 || trap_id !== 2'd2 || trap_vector !== 32'h0001_0020) begin
      fails++; $display("FAIL level_next req=%b id=%0d vec=%h exp 1/2/00010020", trap_req, trap_id, trap_vector);
    end
    trap_ack = 1; trap_pc = 32'h300; tick(); trap_ack = 0;
    irq_in = 0; mret = 1; tick(); mret = 0; tick();
    tests++;
    if (dut_vec() !== model_vec()) begin
      fails++; $display("FAIL level_end got=%h exp=%h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_stall();
    irq_in = 4'b1000; tick(); tick();
    stall = 1; trap_ack = 1; trap_pc = 32'hDEAD_0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (trap_req !== 1'b1 || ret_pc !== 32'h300) begin
        fails++; $display("FAIL stall_hold%0d req=%b epc=%h exp 1/00000300", k, trap_req, ret_pc);
      end
    end
    stall = 0; tick(); trap_ack = 0;
    tests++;
    if (trap_req !== 1'b0 || ret_pc !== 32'hDEAD_0000 || dut_vec() !== model_vec()) begin
      fails++; $display("FAIL stall_release req=%b epc=%h exp 0/dead0000", trap_req, ret_pc);
    end
    irq_in = 0; mret = 1; tick(); mret = 0; tick();
  endtask

  task automatic test_gie_mask();
    gie_wr = 1; gie_wdata = 0; tick(); gie_wr = 0;
    irq_in = 4'b1000; tick(); tick();
    tests++;
    if (trap_req !== 1'b0 || pending[3] !== 1'b1) begin
      fails++; $display("FAIL gie_off req=%b pend=%b exp 0/1xxx", trap_req, pending);
    end
    gie_wr = 1; gie_wdata = 1; tick(); gie_wr = 0;
    tick();
    tests++;
    if (trap_req !== 1'b1 || trap_id !== 2'd3) begin
      fails++; $display("FAIL gie_on req=%b id=%0d exp 1/3", trap_req, trap_id);
    end
    mask_wr = 1; mask_wdata = 4'b0111; tick(); mask_wr = 0;
    tests++;
    if (trap_req !== 1'b0) begin
      fails++; $display("FAIL mask_withdraw req=%b exp 0", trap_req);
    end
    tick();
    tests++;
    if (trap_req !== 1'b0 || dut_vec() !== model_vec()) begin
      fails++; $display("FAIL mask_blocked got=%h exp=%h", dut_vec(), model_vec());
    end
    irq_in = 0; mask_wr = 1; mask_wdata = 4'hF; tick(); mask_wr = 0; tick();
  endtask

  task automatic test_wdt();
    int pulses = 0;
    irq_in = 4'b0010; tick(); tick();
    trap_ack = 1; trap_pc = 32'h440; tick(); trap_ack = 0;
    irq_in = 0; wdt_timeout = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (sys_reset === 1'b1) pulses++;
    end
    wdt_timeout = 0; tick();
    if (sys_reset === 1'b1) pulses++;
    tests++;
    if (pulses != 1) begin
      fails++; $display("FAIL wdt_pulses got=%0d exp=1", pulses);
    end
    tests++;
    if (gie !== 1'b0 || trap_req !== 1'b0 || pending !== 4'b0000 || ret_pc !== 32'h440) begin
      fails++; $display("FAIL wdt_state gie=%b req=%b pend=%b epc=%h exp 0/0/0000/00000440", gie, trap_req, pending, ret_pc);
    end
    gie_wr = 1; gie_wdata = 1; irq_in = 4'b0100; tick(); gie_wr = 0; tick();
    tests++;
    if (trap_req !== 1'b1 || trap_id !== 2'd2) begin
      fails++; $display("FAIL wdt_mask_kept req=%b id=%0d exp 1/2", trap_req, trap_id);
    end
    irq_in = 0; trap_ack = 1; tick(); trap_ack = 0; mret = 1; tick(); mret = 0; tick();
  endtask

  task automatic test_edge_collision();
    irq_in = 4'b0001; tick(); irq_in = 0; tick();
    irq_in = 4'b0001; trap_ack = 1; tick(); trap_ack = 0; irq_in = 0;
    tests++;
    if (pending[0] !== 1'b1 || trap_req !== 1'b0) begin
      fails++; $display("FAIL edge_set_wins pend=%b req=%b exp xxx1/0", pending, trap_req);
    end
    mret = 1; tick(); mret = 0; tick();
    tests++;
    if (trap_req !== 1'b1 || trap_id !== 2'd0 || dut_vec() !== model_vec()) begin
      fails++; $display("FAIL edge_reservice req=%b id=%0d exp 1/0", trap_req, trap_id);
    end
    trap_ack = 1; tick(); trap_ack = 0; mret = 1; tick(); mret = 0; tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst         = ($urandom_range(0, 299) != 0);
      wdt_timeout = ($urandom_range(0, 59) == 0) ? ~wdt_timeout : (wdt_timeout && $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) irq_in = 4'($urandom);
      gie_wr      = ($urandom_range(0, 19) == 0);
      gie_wdata   = ($urandom_range(0, 3) != 0);
      mask_wr     = ($urandom_range(0, 29) == 0);
      mask_wdata  = 4'($urandom);
      stall       = ($urandom_range(0, 3) == 0);
      trap_ack    = ($urandom_range(0, 1) == 0);
      mret        = ($urandom_range(0, 7) == 0);
      trap_pc     = $urandom;
      tick();
      tests++;
      if (dut_vec() !== model_vec()) begin
        fails++; $display("FAIL random_cyc%0d got=%h exp=%h", c, dut_vec(), model_vec());
      end
    end
    idle_inputs();
    rst = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_level_priority();
    test_stall();
    test_gie_mask();
    test_wdt();
    test_edge_collision();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Multi-channel interrupt controller that replaces the two hard-wired interrupt inputs (DMA, WDT) with N parametrised sources.
- Latches and masks requests, and arbitrates by fixed priority.
- Requests a trap from the pipeline with a req/ack handshake, saves the return PC and supplies a per-channel ISR vector; handles mret.
- Sits beside the EXE-stage CSR logic and drives the PC-select / flush controls.

Parameters:
N_IRQ, 4, number of maskable interrupt channels (1..16); channel 0 has highest priority
EDGE_MASK, 4'b0001, per-channel mode: 1 = rising-edge triggered, 0 = level
VEC_BASE, 32'h0001_0000, ISR vector of channel 0
VEC_STRIDE, 32'h0000_0010, byte distance between consecutive channel vectors

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
irq_in  in  N_IRQ  raw interrupt lines
wdt_timeout  in  1  non-maskable watchdog timeout
mask_wr  in  1  write enable for per-channel mask
mask_wdata  in  N_IRQ  new mask (1 = enabled)
gie_wr  in  1  write enable for global interrupt enable
gie_wdata  in  1  new global enable
stall  in  1  pipeline stall (IM/DM/CSR); blocks trap acceptance
trap_pc  in  32  PC of the instruction in EXE, saved as return PC
trap_ack  in  1  pipeline accepts the trap this cycle
mret  in  1  mret executing in EXE
trap_req  out  1  trap request to the PC/flush logic
trap_vector  out  32  ISR target PC, valid while trap_req=1
trap_id  out  $clog2(N_IRQ)  winning channel, valid while trap_req=1 or in ISR
ret_valid  out  1  one-cycle pulse: redirect the PC to ret_pc
ret_pc  out  32  saved return PC (epc)
sys_reset  out  1  one-cycle reset pulse to the pipeline registers
gie  out  1  current global enable
pending  out  N_IRQ  registered pending bits (for CSR readback)

Behaviour:
- Reset (rst=0 at a clk edge):
  - state IDLE, gie=0, mpie=0, mask=0, pending=0, prev_irq=0, epc=0.
  - All outputs read 0, except trap_vector, which reads VEC_BASE.
- Pending update, every cycle:
  - Edge channel: the bit sets when irq_in=1 and prev_irq=0. It clears only on trap acceptance for that channel. If a set and a clear hit the same bit in the same cycle, set wins.
  - Level channel: pending[i] <= irq_in[i]. No clear on acceptance.
  - prev_irq <= irq_in.
- Eligibility: elig = pending & mask. The winner is the lowest index set in elig.
- State IDLE:
  - If gie=1 and elig≠0 → REQ.
  - The winner is latched into trap_id and is frozen for the rest of REQ.
- State REQ:
  - trap_req=1; trap_vector = VEC_BASE + trap_id*VEC_STRIDE, modulo 2^32.
  - On trap_ack=1 and stall=0 → ISR. On that cycle: epc<=trap_pc, mpie<=gie, gie<=0, and the pending bit clears if the channel is edge-triggered.
  - trap_ack while stall=1 is ignored; the request holds.
  - A gie_wr writing 0 during REQ, or a mask_wr clearing the latched channel, withdraws the request: return to IDLE next cycle with trap_req=0.
- State ISR:
  - No nesting; new requests only accumulate in pending.
  - On mret=1 and stall=0 → IDLE, gie<=mpie, ret_valid=1 for exactly that next cycle, ret_pc=epc.
- mret in IDLE or REQ is ignored: no ret_valid, gie unchanged.
- gie_wr in IDLE or ISR updates gie directly.
- Write conflict: if gie_wr coincides with trap acceptance or mret, the hardware update wins.
- Latency: an irq_in rising edge sampled at edge t gives pending=1 after t and trap_req=1 after t+1. Assumes gie=1, mask=1 and state IDLE.
- Watchdog:
  - wdt_timeout=1 overrides all states and events.
  - Next cycle: sys_reset=1 for one cycle, state IDLE, gie=0, mpie=0, pending=0, trap_req=0. mask and epc are kept.
  - If wdt_timeout is held high, sys_reset pulses only once per rising edge of wdt_timeout.
- rst=0 mid-operation (any state) fully reinitialises, including mask. sys_reset is not asserted.

Test Plan:
- N_IRQ=4, gie=1, mask=4'b1111, pulse irq_in[0] for 1 cycle → trap_req high 2 cycles later, trap_vector=32'h0001_0000, trap_id=0; ack with trap_pc=32'h100 → gie=0, pending[0]=0; mret → ret_valid one cycle with ret_pc=32'h100, gie=1.
- irq_in=4'b0110 (level) asserted together → trap_id=1, vector=32'h0001_0010; after mret with irq_in[1] dropped, channel 2 is taken with vector 32'h0001_0020.
- Hold stall=1 with trap_ack=1 for 3 cycles → trap_req stays 1 and epc is unchanged; drop stall → accepted on that cycle.
- gie=0 with pending[3]=1 → no trap_req; then gie_wr=1 with gie_wdata=1 → trap_req after 1 cycle. Also clear mask[3] while in REQ → trap_req drops next cycle.
- In ISR, assert wdt_timeout=1 for 4 cycles → exactly one sys_reset pulse, state IDLE, gie=0, pending=0, mask retained.
- Edge channel 0: irq_in[0] rises on the same cycle as acceptance of channel 0 → pending[0] remains 1 and is serviced after mret.
